opcode_arbiter_rr: RTL and testbench

OPCODE_ARBITER_RR -- requirements
Module: opcode_arbiter_rr

---
 rtl/opcode_arbiter_rr.sv | 152 +++++++++++++++
 tb/tb_opcode_arbiter_rr.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/opcode_arbiter_rr.sv
// opcode_arbiter_rr: four requesters share one opcode path. Ownership is
// granted round-robin and held until the consumer acks. On ack the next owner
// is picked on the same edge, so no idle cycle is inserted.
// Optional feature: define OPCODE_ARB_TIMEOUT_EN to add a forced release after
// TIMEOUT_CYCLES busy cycles without ack. The release raises a one-cycle
// timeout pulse.
module opcode_arbiter_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [4:0] op0,
  input  logic [4:0] op1,
  input  logic [4:0] op2,
  input  logic [4:0] op3,
  input  logic       ack,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic [4:0] opcode_out,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] select_nxt;
  logic [4:0] opcode_nxt;
  logic       valid_nxt;
  logic [1:0] search_ptr;
  logic [2:0] pick;
  logic       load;
  logic       expire;
  logic       release_now;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("opcode_arbiter_rr: TIMEOUT_CYCLES must be within 1..255");
  end

  // Round-robin search from p: the lowest offset from p with a set request
  // wins. The loop runs downward so that the nearest hit is written last.
  // Result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // When idle, the search starts at ptr. When releasing, it starts at the
  // slot after the owner, which is also the new ptr.
  assign search_ptr  = (state == BUSY) ? 2'(select + 2'd1) : ptr;
  assign pick        = rr_pick(req, search_ptr);
  assign release_now = (state == BUSY) && (ack || expire);

`ifdef OPCODE_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       timeout_q;

  // Expire on the busy edge where the count reaches the limit. Ack wins any tie.
  assign expire  = (state == BUSY) && !ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Busy-without-ack counter. It restarts with every new owner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (load || state_nxt == IDLE)
        tmo_cnt <= 8'd0;
      else if (state == BUSY && !ack)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-output decode. Every output is registered below.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    select_nxt = select;
    opcode_nxt = opcode_out;
    valid_nxt  = valid;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (pick[2]) load = 1'b1;
      end
      BUSY: begin
        if (release_now) begin
          ptr_nxt = search_ptr;
          if (pick[2]) begin
            load = 1'b1;
          end else begin
            state_nxt  = IDLE;
            grant_nxt  = 4'b0000;
            opcode_nxt = 5'd0;
            valid_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      state_nxt  = BUSY;
      grant_nxt  = 4'b0001 << pick[1:0];
      select_nxt = pick[1:0];
      valid_nxt  = 1'b1;
      case (pick[1:0])
        2'd0:    opcode_nxt = op0;
        2'd1:    opcode_nxt = op1;
        2'd2:    opcode_nxt = op2;
        default: opcode_nxt = op3;
      endcase
    end
  end

  // State, pointer and output registers. Reset clears all of them at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      grant      <= 4'b0000;
      select     <= 2'd0;
      opcode_out <= 5'd0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      grant      <= grant_nxt;
      select     <= select_nxt;
      opcode_out <= opcode_nxt;
      valid      <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_opcode_arbiter_rr.sv
// Directed bench for opcode_arbiter_rr. The default build has the timeout
// feature off. When OPCODE_ARB_TIMEOUT_EN is defined, the forced-release
// section runs with TIMEOUT_CYCLES = 4.
module tb_opcode_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [4:0] op0, op1, op2, op3;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] select;
  logic [4:0] opcode_out;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  opcode_arbiter_rr #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .req(req),
    .op0(op0), .op1(op1), .op2(op2), .op3(op3),
    .ack(ack), .grant(grant), .select(select),
    .opcode_out(opcode_out), .valid(valid), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic [4:0] o, input logic v);
    chk({tag, ".grant"},  8'(grant),      8'(g));
    chk({tag, ".select"}, 8'(select),     8'(s));
    chk({tag, ".opcode"}, 8'(opcode_out), 8'(o));
    chk({tag, ".valid"},  8'(valid),      8'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 4'b0000; ack = 1'b0;
    op0 = 5'h00; op1 = 5'h00; op2 = 5'h00; op3 = 5'h00;
    tick(); tick();
    chk_all("reset", 4'b0000, 2'd0, 5'h00, 1'b0);
    chk("reset.timeout", 8'(timeout), 8'h0);
    reset = 1'b0;

    // Single requester, then release by ack.
    req = 4'b0001; op0 = 5'h0A;
    tick();
    chk_all("single", 4'b0001, 2'd0, 5'h0A, 1'b1);
    ack = 1'b1; req = 4'b0000;
    tick();
    chk_all("single_rel", 4'b0000, 2'd0, 5'h00, 1'b0);

    // The pointer is now 1, so with all four requesting, requester 1 goes first.
    ack = 1'b0; req = 4'b1111;
    op0 = 5'h11; op1 = 5'h12; op2 = 5'h13; op3 = 5'h14;
    tick();
    chk_all("rr0", 4'b0010, 2'd1, 5'h12, 1'b1);
    ack = 1'b1;
    tick(); chk_all("rr1", 4'b0100, 2'd2, 5'h13, 1'b1);
    tick(); chk_all("rr2", 4'b1000, 2'd3, 5'h14, 1'b1);
    tick(); chk_all("rr3", 4'b0001, 2'd0, 5'h11, 1'b1);
    tick(); chk_all("rr4", 4'b0010, 2'd1, 5'h12, 1'b1);
    req = 4'b0000;
    tick(); chk_all("rr_idle", 4'b0000, 2'd1, 5'h00, 1'b0);

    // Requester 2 holds ownership while its opcode and request change.
    ack = 1'b0; req = 4'b0100; op2 = 5'h03;
    tick(); chk_all("hold0", 4'b0100, 2'd2, 5'h03, 1'b1);
    op2 = 5'h1F; req = 4'b0001;
    tick(); chk_all("hold1", 4'b0100, 2'd2, 5'h03, 1'b1);
    tick(); chk_all("hold2", 4'b0100, 2'd2, 5'h03, 1'b1);
    ack = 1'b1;
    tick(); chk_all("hold_handoff", 4'b0001, 2'd0, 5'h11, 1'b1);
    req = 4'b0000;
    tick(); chk_all("hold_idle", 4'b0000, 2'd0, 5'h00, 1'b0);

    // A sole requester wins again back to back, but loses once others request.
    ack = 1'b0; req = 4'b0010;
    tick(); chk_all("sole0", 4'b0010, 2'd1, 5'h12, 1'b1);
    ack = 1'b1;
    tick(); chk_all("sole1", 4'b0010, 2'd1, 5'h12, 1'b1);
    req = 4'b1010;
    tick(); chk_all("sole_other", 4'b1000, 2'd3, 5'h14, 1'b1);
    req = 4'b0000;
    tick(); chk_all("sole_idle", 4'b0000, 2'd3, 5'h00, 1'b0);

    // An ack while idle is ignored, and the pointer stays at 0.
    tick(); chk_all("idle_ack", 4'b0000, 2'd3, 5'h00, 1'b0);
    ack = 1'b0;
    tick(); chk_all("idle_ack2", 4'b0000, 2'd3, 5'h00, 1'b0);
    req = 4'b1111;
    tick(); chk_all("idle_ptr", 4'b0001, 2'd0, 5'h11, 1'b1);
    ack = 1'b1; req = 4'b0000;
    tick(); chk_all("idle_again", 4'b0000, 2'd0, 5'h00, 1'b0);

    // The pointer is now 1. Requester 1 is granted and never acked.
    ack = 1'b0; req = 4'b0010;
    tick(); chk_all("tmo_grant", 4'b0010, 2'd1, 5'h12, 1'b1);
`ifdef OPCODE_ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("tmo_valid", 8'(valid), 8'h1);
      chk("tmo_quiet", 8'(timeout), 8'h0);
    end
    tick();
    chk("tmo_pulse", 8'(timeout), 8'h1);
    chk_all("tmo_regrant", 4'b0010, 2'd1, 5'h12, 1'b1);
    tick();
    chk("tmo_pulse_end", 8'(timeout), 8'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("notmo_valid", 8'(valid), 8'h1);
      chk("notmo_grant", 8'(grant), 8'h2);
      chk("notmo_timeout", 8'(timeout), 8'h0);
    end
`endif
    ack = 1'b1; req = 4'b0000;
    tick(); chk_all("tmo_idle", 4'b0000, 2'd1, 5'h00, 1'b0);

    // Reset in mid-BUSY drops everything without waiting for a clock edge.
    ack = 1'b0; req = 4'b0100;
    tick(); chk_all("rst_busy", 4'b0100, 2'd2, 5'h1F, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all("rst_async", 4'b0000, 2'd0, 5'h00, 1'b0);
    req = 4'b1001;
    tick();
    chk_all("rst_held", 4'b0000, 2'd0, 5'h00, 1'b0);
    reset = 1'b0;
    tick(); chk_all("rst_ptr0", 4'b0001, 2'd0, 5'h11, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
